vmem_fill_arb: RTL and testbench

VMEM_FILL_ARB -- requirements
Module: vmem_fill_arb

---
 rtl/vmem_fill_arb.sv | 167 ++++++++++++++++
 tb/tb_vmem_fill_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_fill_arb.sv
// vmem_fill_arb: rectangle fill engine sharing a single vmem write port
// with a CPU store path. The CPU always wins the port; the engine holds its
// cursor until it gets a free cycle.
module vmem_fill_arb #(
   parameter int FB_DIM = 240,
   parameter int PIX_W  = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cpu_we_i,
   input  logic [15:0]      cpu_addr_i,
   input  logic [PIX_W-1:0] cpu_wdata_i,
   input  logic             cfg_we_i,
   input  logic [1:0]       cfg_sel_i,
   input  logic [15:0]      cfg_wdata_i,
   output logic             vmem_we_o,
   output logic [15:0]      vmem_addr_o,
   output logic [PIX_W-1:0] vmem_wdata_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [8:0] DIM = 9'(FB_DIM);

   state_t state, state_next;

   logic [7:0]       org_x, org_y, size_w, size_h;
   logic [PIX_W-1:0] color;
   logic [7:0]       cur_x, cur_y, last_x, last_y;

   logic [8:0] org_x9, org_y9;
   logic [8:0] room_x, room_y;
   logic [8:0] w_eff, h_eff;
   logic [8:0] last_x9, last_y9;
   logic       empty_rect;
   logic       ctrl_wr, start_req, abort_req;
   logic       grant, last_px;

   // Clip the requested rectangle against the framebuffer edge in 9-bit
   // unsigned arithmetic so an origin past the edge yields an empty fill
   // instead of wrapping.
   always_comb begin
      org_x9     = {1'b0, org_x};
      org_y9     = {1'b0, org_y};
      room_x     = (org_x9 >= DIM) ? 9'd0 : (DIM - org_x9);
      room_y     = (org_y9 >= DIM) ? 9'd0 : (DIM - org_y9);
      w_eff      = ({1'b0, size_w} < room_x) ? {1'b0, size_w} : room_x;
      h_eff      = ({1'b0, size_h} < room_y) ? {1'b0, size_h} : room_y;
      empty_rect = (w_eff == 9'd0) || (h_eff == 9'd0);
      last_x9    = org_x9 + w_eff - 9'd1;
      last_y9    = org_y9 + h_eff - 9'd1;
   end

   // Control decode: abort dominates start when both bits are written.
   assign ctrl_wr   = cfg_we_i && (cfg_sel_i == 2'd3);
   assign start_req = ctrl_wr && cfg_wdata_i[0] && !cfg_wdata_i[1];
   assign abort_req = ctrl_wr && cfg_wdata_i[1];

   // The engine only writes on cycles the CPU leaves the port free.
   assign grant   = (state == FILL) && !cpu_we_i;
   assign last_px = (cur_x == last_x) && (cur_y == last_y);

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: empty rectangles skip straight to DONE, abort exits
   // FILL silently, and the final granted pixel moves to DONE for one cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_req) begin
               state_next = empty_rect ? DONE : FILL;
            end
         end
         FILL: begin
            if (abort_req) begin
               state_next = IDLE;
            end else if (grant && last_px) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Configuration registers accept writes only while the engine is idle,
   // so an in-flight fill never sees its parameters change.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         org_x  <= '0;
         org_y  <= '0;
         size_w <= '0;
         size_h <= '0;
         color  <= '0;
      end else if (cfg_we_i && (state == IDLE)) begin
         case (cfg_sel_i)
            2'd0: begin
               org_y <= cfg_wdata_i[15:8];
               org_x <= cfg_wdata_i[7:0];
            end
            2'd1: begin
               size_h <= cfg_wdata_i[15:8];
               size_w <= cfg_wdata_i[7:0];
            end
            2'd2: begin
               color <= cfg_wdata_i[PIX_W-1:0];
            end
            default: begin
            end
         endcase
      end
   end

   // Cursor: loaded with the clipped rectangle on start, advanced in
   // row-major order only on granted cycles so a lost cycle retries the
   // same address.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cur_x  <= '0;
         cur_y  <= '0;
         last_x <= '0;
         last_y <= '0;
      end else if ((state == IDLE) && start_req) begin
         cur_x  <= org_x;
         cur_y  <= org_y;
         last_x <= last_x9[7:0];
         last_y <= last_y9[7:0];
      end else if (grant && !last_px) begin
         if (cur_x == last_x) begin
            cur_x <= org_x;
            cur_y <= cur_y + 8'd1;
         end else begin
            cur_x <= cur_x + 8'd1;
         end
      end
   end

   // Port mux: CPU passes straight through; otherwise the engine drives
   // the port while filling.
   always_comb begin
      vmem_we_o    = cpu_we_i || (state == FILL);
      vmem_addr_o  = cpu_we_i ? cpu_addr_i : {cur_y, cur_x};
      vmem_wdata_o = cpu_we_i ? cpu_wdata_i : color;
   end

   assign busy_o = (state == FILL);
   assign done_o = (state == DONE);

endmodule

// File: tb/tb_vmem_fill_arb.sv
// Randomized self-checking bench for vmem_fill_arb. The reference model
// builds the expected list of engine writes from the clipped rectangle and
// consumes it on every cycle the CPU leaves the port free.
module tb_vmem_fill_arb;

   localparam int FB = 240;
   localparam int PW = 3;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          cpu_we_i = 1'b0;
   logic [15:0]   cpu_addr_i = '0;
   logic [PW-1:0] cpu_wdata_i = '0;
   logic          cfg_we_i = 1'b0;
   logic [1:0]    cfg_sel_i = '0;
   logic [15:0]   cfg_wdata_i = '0;
   logic          vmem_we_o;
   logic [15:0]   vmem_addr_o;
   logic [PW-1:0] vmem_wdata_o;
   logic          busy_o;
   logic          done_o;

   int checks = 0;
   int passes = 0;

   vmem_fill_arb #(.FB_DIM(FB), .PIX_W(PW)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cpu_we_i    (cpu_we_i),
      .cpu_addr_i  (cpu_addr_i),
      .cpu_wdata_i (cpu_wdata_i),
      .cfg_we_i    (cfg_we_i),
      .cfg_sel_i   (cfg_sel_i),
      .cfg_wdata_i (cfg_wdata_i),
      .vmem_we_o   (vmem_we_o),
      .vmem_addr_o (vmem_addr_o),
      .vmem_wdata_o(vmem_wdata_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   // Apply one cycle of inputs just after the rising edge.
   task automatic drive(input logic cw, input logic [15:0] ca, input logic [PW-1:0] cd,
                        input logic gw, input logic [1:0] gs, input logic [15:0] gd);
      @(posedge clk_i);
      #1;
      cpu_we_i    = cw;
      cpu_addr_i  = ca;
      cpu_wdata_i = cd;
      cfg_we_i    = gw;
      cfg_sel_i   = gs;
      cfg_wdata_i = gd;
   endtask

   // Configure (registers selected by mask: 1 origin, 2 size, 4 color),
   // start, then check every cycle until the fill ends. The model values
   // ox/oy/w/h/col are what the registers are expected to hold.
   // cpu_mode: 0 no CPU traffic, 1 CPU on odd cycles, 2 random CPU traffic.
   // abort_k > 0 aborts in the cycle of the k-th granted engine write.
   // junk=1 writes color/origin and start while busy, and start during DONE.
   task automatic do_fill(input string name, input int ox, input int oy, input int w,
                          input int h, input int col, input int mask, input int cpu_mode,
                          input int abort_k, input bit junk);
      int q[$];
      int weff, heff, grants, post;
      bit aborted, done_seen, in_fill, pred_done, abort_now;
      logic cw, gw;
      logic [15:0] ca, gd;
      logic [PW-1:0] cd;
      logic [1:0] gs;
      if ((mask & 1) != 0) drive(1'b0, 16'h0, '0, 1'b1, 2'd0, 16'((oy << 8) | ox));
      if ((mask & 2) != 0) drive(1'b0, 16'h0, '0, 1'b1, 2'd1, 16'((h << 8) | w));
      if ((mask & 4) != 0) drive(1'b0, 16'h0, '0, 1'b1, 2'd2, 16'(col));
      weff = (ox >= FB) ? 0 : ((w < FB - ox) ? w : FB - ox);
      heff = (oy >= FB) ? 0 : ((h < FB - oy) ? h : FB - oy);
      for (int y = 0; y < heff; y++)
         for (int x = 0; x < weff; x++)
            q.push_back(((oy + y) << 8) | (ox + x));
      drive(1'b0, 16'h0, '0, 1'b1, 2'd3, 16'h0001);
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || vmem_we_o !== 1'b0)
         $display("[TB] FAIL %s start_cycle: busy/done/we got %b%b%b want 000", name, busy_o, done_o, vmem_we_o);
      else passes++;
      grants = 0; post = 0; aborted = 0; done_seen = 0;
      for (int cyc = 1; cyc <= 400 && post < 4; cyc++) begin
         cw = (cpu_mode == 1) ? logic'(cyc % 2) : (cpu_mode == 2) ? logic'($urandom_range(0, 1)) : 1'b0;
         ca = 16'($urandom);
         cd = PW'($urandom);
         gw = 1'b0; gs = 2'd0; gd = 16'h0;
         pred_done = !aborted && !done_seen && (q.size() == 0);
         abort_now = (abort_k > 0) && !aborted && (grants == abort_k - 1) && !cw && (q.size() > 0);
         if (abort_now) begin
            gw = 1'b1; gs = 2'd3; gd = 16'h0002;
         end else if (junk && cyc == 2) begin
            gw = 1'b1; gs = 2'd2; gd = 16'((~col) & 7);
         end else if (junk && cyc == 3) begin
            gw = 1'b1; gs = 2'd0; gd = 16'h0505;
         end else if (junk && (cyc == 4 || pred_done)) begin
            gw = 1'b1; gs = 2'd3; gd = 16'h0001;
         end
         drive(cw, ca, cd, gw, gs, gd);
         @(negedge clk_i);
         in_fill = !aborted && !done_seen && (q.size() > 0);
         checks++;
         if (busy_o !== in_fill)
            $display("[TB] FAIL %s busy cyc%0d: got %b want %b", name, cyc, busy_o, in_fill);
         else passes++;
         checks++;
         if (done_o !== pred_done)
            $display("[TB] FAIL %s done cyc%0d: got %b want %b", name, cyc, done_o, pred_done);
         else passes++;
         checks++;
         if (vmem_we_o !== (cw | in_fill))
            $display("[TB] FAIL %s vmem_we cyc%0d: got %b want %b", name, cyc, vmem_we_o, cw | in_fill);
         else passes++;
         if (cw) begin
            checks++;
            if (vmem_addr_o !== ca || vmem_wdata_o !== cd)
               $display("[TB] FAIL %s cpu_pass cyc%0d: got %h/%0d want %h/%0d", name, cyc, vmem_addr_o, vmem_wdata_o, ca, cd);
            else passes++;
         end else if (in_fill) begin
            checks++;
            if (vmem_addr_o !== 16'(q[0]) || vmem_wdata_o !== PW'(col))
               $display("[TB] FAIL %s fill_write cyc%0d: got %h/%0d want %h/%0d", name, cyc, vmem_addr_o, vmem_wdata_o, 16'(q[0]), col);
            else passes++;
            void'(q.pop_front());
            grants++;
         end
         if (abort_now) aborted = 1;
         if (pred_done) done_seen = 1;
         if (aborted || done_seen) post++;
      end
      checks++;
      if (!(aborted || done_seen))
         $display("[TB] FAIL %s timeout: got %0d grants want %0d", name, grants, weff * heff);
      else passes++;
   endtask

   // Reset holds the engine idle and leaves the port to the CPU alone.
   task automatic test_reset;
      #3;
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || vmem_we_o !== 1'b0)
         $display("[TB] FAIL reset_state: busy/done/we got %b%b%b want 000", busy_o, done_o, vmem_we_o);
      else passes++;
      #9;
      rst_ni = 1'b1;
   endtask

   task automatic test_basic_fill;
      do_fill("basic", 10, 20, 4, 3, 5, 7, 0, 0, 1'b0);
   endtask

   task automatic test_cpu_contention;
      do_fill("contention", 10, 20, 4, 3, 5, 7, 1, 0, 1'b0);
   endtask

   task automatic test_clipping;
      do_fill("clip_x", 238, 0, 5, 1, 2, 7, 0, 0, 1'b0);
      do_fill("clip_off", 240, 0, 3, 3, 2, 1, 0, 0, 1'b0);
      do_fill("clip_y", 100, 237, 2, 9, 6, 7, 2, 0, 1'b0);
   endtask

   task automatic test_zero_size;
      do_fill("zero_w", 5, 5, 0, 7, 1, 7, 0, 0, 1'b0);
   endtask

   task automatic test_abort;
      do_fill("abort", 10, 20, 4, 3, 5, 7, 1, 5, 1'b0);
      do_fill("restart", 10, 20, 4, 3, 5, 0, 0, 0, 1'b0);
   endtask

   // Register writes and starts while busy or done must leave no trace.
   task automatic test_ignored_writes;
      do_fill("busy_writes", 30, 40, 2, 3, 5, 7, 0, 0, 1'b1);
      do_fill("after_busy", 30, 40, 3, 2, 5, 2, 2, 0, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 8; i++) begin
         int ox, oy, w, h, k;
         ox = $urandom_range(180, 255);
         oy = $urandom_range(220, 255);
         w  = $urandom_range(0, 12);
         h  = $urandom_range(0, 5);
         k  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
         do_fill("random", ox, oy, w, h, $urandom_range(0, 7), 7, 2, k, 1'b0);
      end
   endtask

   // Async reset mid-fill, then prove registers cleared and a start on the
   // first edge after release is accepted.
   task automatic test_reset_mid_fill;
      drive(1'b0, 16'h0, '0, 1'b1, 2'd0, 16'h0101);
      drive(1'b0, 16'h0, '0, 1'b1, 2'd1, 16'h0505);
      drive(1'b0, 16'h0, '0, 1'b1, 2'd2, 16'h0006);
      drive(1'b0, 16'h0, '0, 1'b1, 2'd3, 16'h0001);
      for (int i = 0; i < 4; i++) drive(1'b0, 16'h0, '0, 1'b0, 2'd0, 16'h0);
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if (vmem_we_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0)
         $display("[TB] FAIL rst_async: we/busy/done got %b%b%b want 000", vmem_we_o, busy_o, done_o);
      else passes++;
      cpu_we_i = 1'b1; cpu_addr_i = 16'h1234; cpu_wdata_i = 3'd3;
      #1;
      checks++;
      if (vmem_we_o !== 1'b1 || vmem_addr_o !== 16'h1234 || vmem_wdata_o !== 3'd3)
         $display("[TB] FAIL rst_cpu_pass: got %b/%h/%0d want 1/1234/3", vmem_we_o, vmem_addr_o, vmem_wdata_o);
      else passes++;
      cpu_we_i = 1'b0; cfg_we_i = 1'b1; cfg_sel_i = 2'd3; cfg_wdata_i = 16'h0001;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      cfg_we_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || vmem_we_o !== 1'b0)
         $display("[TB] FAIL rst_first_start: done/busy/we got %b%b%b want 100", done_o, busy_o, vmem_we_o);
      else passes++;
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b0)
         $display("[TB] FAIL rst_done_once: got %b want 0", done_o);
      else passes++;
      do_fill("cleared_regs", 0, 0, 2, 1, 0, 2, 0, 0, 1'b0);
   endtask

   initial begin
      test_reset;
      test_basic_fill;
      test_cpu_contention;
      test_clipping;
      test_zero_size;
      test_abort;
      test_ignored_writes;
      test_random;
      test_reset_mid_fill;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
